mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one hex_multiplier instance between NUM_REQ requesters.
- Accepts a request and latches its operands. Drives the multiplier's enable, inputs and top_state. Waits for the multiplier's done, then returns the 17-bit product tagged with the requester index.
- Sits between the requester blocks and the single hex_multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must be at least clog2(NUM_REQ).
- TIMEOUT, 64, watchdog limit in cycles (used only with MUL_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester request level.
- req_a  input  8*NUM_REQ  packed operand 1; slice i belongs to requester i.
- req_b  input  8*NUM_REQ  packed operand 2.
- gnt  output  NUM_REQ  one-hot grant, one-cycle pulse.
- busy  output  1  high while state is not IDLE.
- rsp_valid  output  1  one-cycle result strobe.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- rsp_data  output  17  product.
- rsp_err  output  1  timeout flag, qualified by rsp_valid; tied 0 without the feature.
- mul_enable  output  1  to multiplier enable.
- mul_in_1  output  8  to multiplier in_1.
- mul_in_2  output  8  to multiplier in_2.
- mul_top_state  output  3  to multiplier top_state.
- mul_out_data  input  17  from multiplier out_data.
- mul_done  input  1  from multiplier done.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; gnt=0; busy=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_err=0; mul_enable=0; mul_in_1=0; mul_in_2=0; mul_top_state=3'd0. Round-robin pointer resets to 0, so requester 0 has highest priority first.
- All outputs are registered.
- States and mul_top_state encoding: IDLE=0, BUSY=1, RESP=2.
- IDLE:
  - If any req bit is high at edge T, select the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - At T+1: gnt[sel]=1 for exactly one cycle. mul_in_1/mul_in_2 hold the latched slices of req_a/req_b. rsp_id=sel. mul_enable=1. ptr=(sel+1) mod NUM_REQ. State goes to BUSY.
- BUSY:
  - mul_enable stays 1 and mul_in_1/mul_in_2 stay stable.
  - If mul_done is high at edge D: rsp_data<=mul_out_data and state goes to RESP. At D+1: rsp_valid=1 and mul_enable=0.
- RESP: rsp_valid lasts one cycle, then state goes to IDLE. rsp_data and rsp_id hold until the next capture.
- Throughput: at most one request is granted per IDLE visit, and there is no grant in RESP. Minimum spacing between grants is done latency plus 3 cycles.
- Requester rules:
  - Operands must be stable while req is high and until gnt is seen.
  - Requester must drop req in the cycle after gnt. A req still high on the next IDLE visit is a new request.
  - Dropping req before grant withdraws it silently.
- No backpressure on the response: a requester must accept rsp_valid when its rsp_id matches.
- mul_done is ignored in IDLE and RESP.
- Simultaneous requests are resolved by round robin. The starvation bound is NUM_REQ-1 intervening grants.
- Reset mid-operation (any state): outputs and ptr return to reset values on the next edge. An in-flight result is discarded and no rsp_valid is issued.
- Widths: the product is passed through unmodified, with no truncation or sign handling.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- With the macro: an 8-bit-or-wider watchdog counter clears on entry to BUSY and increments each BUSY cycle. If it reaches TIMEOUT without mul_done, the next cycle enters RESP with rsp_valid=1, rsp_err=1, rsp_data=0 and mul_enable=0. If mul_done and the limit coincide, mul_done wins with rsp_err=0.
- Without the macro: no counter, BUSY waits indefinitely, rsp_err is constant 0.

Test Plan:
- Reset, then req=4'b0010 with req_a[15:8]=8'h12, req_b[15:8]=8'h34 -> gnt=4'b0010 one cycle later; mul_in_1=8'h12, mul_in_2=8'h34, mul_enable=1. Model done after 5 cycles with 17'h003A8 -> rsp_valid one cycle after done, rsp_id=1, rsp_data=17'h003A8.
- All four req high continuously, each requester re-raising after its response -> grant order 0,1,2,3,0, one gnt per transaction.
- req=4'b1001 after requester 3 was last served -> requester 0 granted first, then 3.
- rst asserted in BUSY with mul_done pulsing the same cycle -> no rsp_valid; all outputs zero next cycle; ptr=0.
- mul_done pulsed in IDLE with no req -> no state change, rsp_valid stays 0.
- With MUL_ARB_TIMEOUT_EN and TIMEOUT=16, multiplier never asserts done -> rsp_valid=1, rsp_err=1, rsp_data=0 after 16 BUSY cycles, then IDLE. Without the macro, busy stays high.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sequencer sharing one hex_multiplier among NUM_REQ requesters
// Optional busy watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]     gnt,
   output logic                   busy,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [16:0]            rsp_data,
   output logic                   rsp_err,
   output logic                   mul_enable,
   output logic [7:0]             mul_in_1,
   output logic [7:0]             mul_in_2,
   output logic [2:0]             mul_top_state,
   input  logic [16:0]            mul_out_data,
   input  logic                   mul_done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_BUSY = 3'd1,
      S_RESP = 3'd2
   } state_t;

   localparam logic [ID_W:0]   NR_W    = NUM_REQ[ID_W:0];
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) || TIMEOUT < 1) begin : g_bad_cfg
      $error("mul_share_arbiter: illegal parameter set");
   end

   state_t              state;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     off;
   logic [ID_W-1:0]     sel;
   logic [ID_W-1:0]     ptr_nxt;
   logic [ID_W:0]       sum;
   logic [NUM_REQ-1:0]  req_rot;
   logic                found;
   logic [NUM_REQ-1:0]  gnt_nxt;
   logic [7:0]          op_a;
   logic [7:0]          op_b;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
   logic [WD_W-1:0] wdog;
`endif

   // Rotate so bit 0 is the current priority holder; first set bit is the winner offset.
   always_comb begin
      req_rot = NUM_REQ'({req, req} >> ptr);
      found   = 1'b0;
      off     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_rot[i]) begin
            found = 1'b1;
            off   = ID_W'(i);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= NR_W) begin
         sum = sum - NR_W;
      end
      sel     = sum[ID_W-1:0];
      ptr_nxt = (sel == LAST_ID) ? '0 : sel + 1'b1;
      gnt_nxt = '0;
      op_a    = '0;
      op_b    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == ID_W'(i)) begin
            gnt_nxt[i] = 1'b1;
            op_a       = req_a[i*8 +: 8];
            op_b       = req_b[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         ptr           <= '0;
         gnt           <= '0;
         busy          <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_data      <= '0;
         mul_enable    <= 1'b0;
         mul_in_1      <= '0;
         mul_in_2      <= '0;
         mul_top_state <= S_IDLE;
`ifdef MUL_ARB_TIMEOUT_EN
         rsp_err       <= 1'b0;
         wdog          <= '0;
`endif
      end else begin
         gnt <= '0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  gnt           <= gnt_nxt;
                  mul_in_1      <= op_a;
                  mul_in_2      <= op_b;
                  rsp_id        <= sel;
                  mul_enable    <= 1'b1;
                  ptr           <= ptr_nxt;
                  busy          <= 1'b1;
                  state         <= S_BUSY;
                  mul_top_state <= S_BUSY;
`ifdef MUL_ARB_TIMEOUT_EN
                  wdog          <= '0;
`endif
               end
            end
            S_BUSY: begin
               // A done coinciding with the watchdog limit is still a good result.
               if (mul_done) begin
                  rsp_data      <= mul_out_data;
                  rsp_valid     <= 1'b1;
                  mul_enable    <= 1'b0;
                  state         <= S_RESP;
                  mul_top_state <= S_RESP;
`ifdef MUL_ARB_TIMEOUT_EN
                  rsp_err       <= 1'b0;
`endif
               end
`ifdef MUL_ARB_TIMEOUT_EN
               else if (wdog == WD_LIMIT) begin
                  rsp_data      <= '0;
                  rsp_valid     <= 1'b1;
                  rsp_err       <= 1'b1;
                  mul_enable    <= 1'b0;
                  state         <= S_RESP;
                  mul_top_state <= S_RESP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
`endif
            end
            S_RESP: begin
               rsp_valid     <= 1'b0;
               busy          <= 1'b0;
               state         <= S_IDLE;
               mul_top_state <= S_IDLE;
`ifdef MUL_ARB_TIMEOUT_EN
               rsp_err       <= 1'b0;
`endif
            end
            default: begin
               rsp_valid     <= 1'b0;
               mul_enable    <= 1'b0;
               busy          <= 1'b0;
               state         <= S_IDLE;
               mul_top_state <= S_IDLE;
            end
         endcase
      end
   end

`ifndef MUL_ARB_TIMEOUT_EN
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter
// Table-driven grants plus a response scoreboard and hand-written corner sequences.
module tb_mul_share_arbiter;

   localparam int NR = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req = '0;
   logic [8*NR-1:0] req_a = '0;
   logic [8*NR-1:0] req_b = '0;
   logic [NR-1:0]   gnt;
   logic            busy;
   logic            rsp_valid;
   logic [IW-1:0]   rsp_id;
   logic [16:0]     rsp_data;
   logic            rsp_err;
   logic            mul_enable;
   logic [7:0]      mul_in_1;
   logic [7:0]      mul_in_2;
   logic [2:0]      mul_top_state;
   logic [16:0]     mul_out_data;
   logic            mul_done;

   logic            mul_auto = 1'b0;
   int              mul_lat = 5;
   int              mcnt = 0;
   logic            auto_done = 1'b0;
   logic [16:0]     auto_data = '0;
   logic            man_done = 1'b0;
   logic [16:0]     man_data = '0;

   int checks = 0;
   int errors = 0;
   int gnt_cnt = 0;

   typedef struct {
      logic [IW-1:0] id;
      logic [16:0]   data;
      logic          err;
   } rsp_t;
   rsp_t sb[$];

   typedef struct {
      logic [NR-1:0] req;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [NR-1:0] eg;
      logic [7:0]    in1;
      logic [7:0]    in2;
   } vec_t;
   vec_t tbl[9];

   mul_share_arbiter #(.NUM_REQ(NR), .ID_W(IW), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .mul_enable(mul_enable),
      .mul_in_1(mul_in_1), .mul_in_2(mul_in_2), .mul_top_state(mul_top_state),
      .mul_out_data(mul_out_data), .mul_done(mul_done)
   );

   always #5 clk = ~clk;

   assign mul_done     = mul_auto ? auto_done : man_done;
   assign mul_out_data = mul_auto ? auto_data : man_data;

   // Multiplier model: done pulse mul_lat cycles after enable rises.
   always @(negedge clk) begin
      if (!mul_auto || !mul_enable) begin
         mcnt = 0;
         auto_done = 1'b0;
      end else if (auto_done) begin
         auto_done = 1'b0;
      end else begin
         mcnt++;
         if (mcnt == mul_lat) begin
            auto_done = 1'b1;
            auto_data = 17'(mul_in_1) * 17'(mul_in_2);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (gnt != '0) gnt_cnt++;
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=id%0h/data%0h required=no_response", rsp_id, rsp_data);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
            chk("sb_rsp_data", 32'(rsp_data), 32'(e.data));
            chk("sb_rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
   end

   function automatic int idx_of(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [7:0] sl(input logic [31:0] v, input int i);
      return v[i*8 +: 8];
   endfunction

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (gnt != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL gnt_wait actual=no_grant required=grant_within_20");
      end
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL rsp_wait actual=no_rsp required=rsp_within_60");
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_gnt"}, 32'(gnt), 32'(0));
      chk({nm, "_busy"}, 32'(busy), 32'(0));
      chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
      chk({nm, "_rsp_id"}, 32'(rsp_id), 32'(0));
      chk({nm, "_rsp_data"}, 32'(rsp_data), 32'(0));
      chk({nm, "_rsp_err"}, 32'(rsp_err), 32'(0));
      chk({nm, "_mul_enable"}, 32'(mul_enable), 32'(0));
      chk({nm, "_mul_in_1"}, 32'(mul_in_1), 32'(0));
      chk({nm, "_mul_in_2"}, 32'(mul_in_2), 32'(0));
      chk({nm, "_top_state"}, 32'(mul_top_state), 32'(0));
   endtask

   task automatic run_txn(input vec_t v, input string nm);
      bit ok;
      int idx;
      req = v.req;
      req_a = v.a;
      req_b = v.b;
      wait_gnt(ok);
      if (ok) begin
         idx = idx_of(v.eg);
         chk({nm, "_gnt"}, 32'(gnt), 32'(v.eg));
         chk({nm, "_in1"}, 32'(mul_in_1), 32'(v.in1));
         chk({nm, "_in2"}, 32'(mul_in_2), 32'(v.in2));
         chk({nm, "_enable"}, 32'(mul_enable), 32'(1));
         chk({nm, "_top_busy"}, 32'(mul_top_state), 32'(1));
         chk({nm, "_rsp_id"}, 32'(rsp_id), 32'(idx));
         sb.push_back('{IW'(idx), 17'(v.in1) * 17'(v.in2), 1'b0});
         req = '0;
         wait_rsp(ok);
         if (ok) begin
            chk({nm, "_enable_off"}, 32'(mul_enable), 32'(0));
            chk({nm, "_top_resp"}, 32'(mul_top_state), 32'(2));
            @(posedge clk); #1;
            chk({nm, "_valid_1cyc"}, 32'(rsp_valid), 32'(0));
            chk({nm, "_idle_busy"}, 32'(busy), 32'(0));
         end
      end
      req = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      bit ok;
      int g0;
      int n;
      int ord[5];
      logic [31:0] pa;
      logic [31:0] pb;
      pa = 32'h44332211;
      pb = 32'h88776655;
      ord = '{0, 1, 2, 3, 0};

      tbl[0] = '{4'b0010, 32'h00001200, 32'h00003400, 4'b0010, 8'h12, 8'h34};
      tbl[1] = '{4'b1111, pa, pb, 4'b0100, 8'h33, 8'h77};
      tbl[2] = '{4'b1111, pa, pb, 4'b1000, 8'h44, 8'h88};
      tbl[3] = '{4'b1001, pa, pb, 4'b0001, 8'h11, 8'h55};
      tbl[4] = '{4'b1001, pa, pb, 4'b1000, 8'h44, 8'h88};
      tbl[5] = '{4'b0001, 32'h000000FF, 32'h000000FF, 4'b0001, 8'hFF, 8'hFF};
      tbl[6] = '{4'b1110, pa, pb, 4'b0010, 8'h22, 8'h66};
      tbl[7] = '{4'b1011, pa, pb, 4'b1000, 8'h44, 8'h88};
      tbl[8] = '{4'b0011, pa, pb, 4'b0001, 8'h11, 8'h55};

      do_reset();
      check_zero("reset");

      // mul_done in IDLE must be ignored
      mul_auto = 1'b0;
      man_data = 17'h01555;
      man_done = 1'b1;
      @(posedge clk); #1;
      man_done = 1'b0;
      chk("idle_done_busy", 32'(busy), 32'(0));
      chk("idle_done_top", 32'(mul_top_state), 32'(0));
      chk("idle_done_valid", 32'(rsp_valid), 32'(0));
      @(posedge clk); #1;
      chk("idle_done_valid2", 32'(rsp_valid), 32'(0));

      mul_auto = 1'b1;
      for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Continuous requests: rotation 0,1,2,3,0
      do_reset();
      g0 = gnt_cnt;
      req_a = pa;
      req_b = pb;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(ok);
         if (!ok) break;
         chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1) << ord[k]);
         sb.push_back('{IW'(ord[k]), 17'(sl(pa, ord[k])) * 17'(sl(pb, ord[k])), 1'b0});
         req[ord[k]] = 1'b0;
         wait_rsp(ok);
         if (k < 4) req[ord[k]] = 1'b1;
      end
      req = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rr_gnt_count", 32'(gnt_cnt - g0), 32'(5));

      // Full 17-bit product passes through untouched
      mul_auto = 1'b0;
      req = 4'b0100;
      wait_gnt(ok);
      chk("wide_gnt", 32'(gnt), 32'(4'b0100));
      req = '0;
      sb.push_back('{IW'(2), 17'h1ABCD, 1'b0});
      repeat (3) begin
         @(posedge clk); #1;
         chk("wide_hold_en", 32'(mul_enable), 32'(1));
         chk("wide_hold_in1", 32'(mul_in_1), 32'(8'h33));
      end
      man_data = 17'h1ABCD;
      man_done = 1'b1;
      @(posedge clk); #1;
      man_done = 1'b0;
      chk("wide_valid", 32'(rsp_valid), 32'(1));
      chk("wide_enable", 32'(mul_enable), 32'(0));
      @(posedge clk); #1;
      chk("wide_valid_off", 32'(rsp_valid), 32'(0));
      chk("wide_top_idle", 32'(mul_top_state), 32'(0));

      // Reset in BUSY coincident with done discards the result
      req = 4'b0100;
      wait_gnt(ok);
      chk("rstbusy_gnt", 32'(gnt), 32'(4'b0100));
      req = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      man_data = 17'h1FFFF;
      man_done = 1'b1;
      @(posedge clk); #1;
      check_zero("rstbusy");
      rst = 1'b0;
      man_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rstbusy_no_valid", 32'(rsp_valid), 32'(0));
      end
      mul_auto = 1'b1;
      run_txn('{4'b1010, pa, pb, 4'b0010, 8'h22, 8'h66}, "ptr_after_rst");

      // Multiplier never completes
      mul_auto = 1'b0;
      req = 4'b0001;
      wait_gnt(ok);
      chk("hang_gnt", 32'(gnt), 32'(4'b0001));
      req = '0;
`ifdef MUL_ARB_TIMEOUT_EN
      sb.push_back('{IW'(0), 17'h0, 1'b1});
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         n++;
         if (rsp_valid) break;
      end
      chk("timeout_cycles", 32'(n), 32'(16));
      chk("timeout_enable", 32'(mul_enable), 32'(0));
      @(posedge clk); #1;
      chk("timeout_idle", 32'(busy), 32'(0));
`else
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (busy && mul_enable && !rsp_valid) n++;
      end
      chk("hang_busy_cycles", 32'(n), 32'(40));
      chk("hang_top", 32'(mul_top_state), 32'(1));
      do_reset();
      check_zero("hang_reset");
`endif

      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
